adc_bcd_converter: RTL and testbench
====================================

Name: adc_bcd_converter

Overview:
- Sequential binary-to-BCD converter. Sits directly downstream of the SPI ADC state machine.
- Captures each new 12-bit ADC sample on its data-valid strobe and converts it with the shift-add-3 (double-dabble) algorithm, one bit per clock.
- Presents four registered BCD digits (ones..thousands) to the 7-segment controller, so the display shows the live ADC reading instead of a free-running count.

Parameters:
- DATA_W, 12, width of the input sample (ADC resolution).
- DIGITS, 4, number of BCD output digits; must satisfy 10^DIGITS > 2^DATA_W - 1.

Ports:
- clk  input  1  system clock; the same clock that drives the SPI state machine.
- rst_n  input  1  asynchronous, active-low reset.
- i_data  input  DATA_W  sample from the SPI block.
- i_data_valid  input  1  sample-valid from the SPI block; level or pulse.
- o_ones  output  4  BCD units digit.
- o_tens  output  4  BCD tens digit.
- o_hundreds  output  4  BCD hundreds digit.
- o_thousands  output  4  BCD thousands digit.
- o_busy  output  1  high while a conversion is in progress.
- o_done  output  1  one-cycle pulse when new digits become visible.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all digit outputs 0; o_busy=0; o_done=0; shift register, bit counter and valid-edge register cleared.
- Start condition: rising edge of i_data_valid. The previous valid level is registered; after reset that register is 0, so valid already high at reset release starts exactly one conversion.
- States:
  - IDLE: on a start condition, capture i_data into the shift register, clear the BCD scratch digits, load the bit counter with DATA_W, go to SHIFT.
  - SHIFT: each cycle, add 3 to every scratch digit that is >=5, then shift {scratch, sample} left by 1. Decrement the counter; after the DATA_W-th shift go to DONE.
  - DONE: copy scratch digits to the outputs, pulse o_done for one cycle, return to IDLE.
- o_busy=1 in SHIFT and DONE, 0 in IDLE.
- Latency: capture edge at cycle k -> o_done high and new digits visible during cycle k+DATA_W+1 (13 for the default).
- Next start: earliest start edge is sampled in the cycle after DONE. Maximum throughput is one conversion per DATA_W+2 cycles.
- Start edges while o_busy=1 are dropped, not queued. The conversion in flight completes with its originally captured data.
- Outputs hold their last converted value between conversions; they never show partial results.
- Width rules: scratch digits are 4 bits. The add-3 result before the shift is at most 4'd12, so no digit overflow. The maximum input 4095 fits in 4 digits.
- Reset mid-conversion: immediate abort; outputs return to 0; no o_done is issued.

Optional Feature:
- Macro ADC_BCD_AVG_EN.
- Defined:
  - Accepted samples accumulate into a (DATA_W+2)-bit accumulator.
  - After every 4th accepted sample, the accumulator >>2 (truncating) is converted and the accumulator and sample count clear.
  - Samples dropped while busy are not counted.
  - o_done fires once per 4 accepted samples.
  - Reset clears the accumulator and count.
- Undefined: every accepted sample is converted directly; no accumulator logic is present.

Decomposition:
- Shared package adc_bcd_pkg holds:
  - state encoding (IDLE, SHIFT, DONE);
  - DATA_W and DIGITS defaults;
  - bit-counter width, $clog2(DATA_W+1);
  - add-3 threshold constant 4'd5;
  - averaging depth 4.
- One natural sub-module, bcd_add3: combinational single-digit corrector (in >=5 ? in+3 : in), instantiated DIGITS times inside the SHIFT datapath.

Test Plan:
- Reset: hold rst_n low with i_data=12'hFFF -> all digits 0, o_busy=0, o_done=0. Release with valid low -> outputs stay 0 and no done.
- Basic conversion: i_data=1234 with a 1-cycle valid at cycle k -> o_done only at k+13, digits th/h/t/o = 1/2/3/4, o_busy high for cycles k+1..k+13. Then i_data=4095 -> 4/0/9/5; i_data=0 -> 0/0/0/0.
- Busy drop: valid pulse with 1234, second pulse with 999 five cycles later -> exactly one o_done, digits 1/2/3/4. A third pulse after done with 999 -> 0/9/9/9.
- Level valid: i_data_valid held high for 40 cycles with 0500 -> exactly one conversion, digits 0/5/0/0. The same applies when valid is high across reset release.
- Mid-conversion reset: rst_n pulsed low at cycle 6 of SHIFT -> digits immediately 0, o_busy 0, no o_done. A new valid with 42 afterwards -> 0/0/4/2.
- With ADC_BCD_AVG_EN: samples 1000, 1001, 1002, 1003 (spaced >=14 cycles) -> single o_done after the 4th, digits 1/0/0/1 (4006>>2).

Source files
------------

// File: rtl/adc_bcd_converter_pkg.sv
// Shared types and constants for the ADC sample to BCD converter.
package adc_bcd_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         DEF_DATA_W = 12;
    localparam int         DEF_DIGITS = 4;
    localparam int         CNT_W      = $clog2(DEF_DATA_W + 1);
    localparam logic [3:0] ADD3_TH    = 4'd5;
    localparam int         AVG_DEPTH  = 4;
endpackage

// File: rtl/adc_bcd_converter_bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more, combinational.
module bcd_add3
    import adc_bcd_pkg::*;
(
    input  logic [3:0] i_dig,
    output logic [3:0] o_dig
);
    assign o_dig = (i_dig >= ADD3_TH) ? (i_dig + 4'd3) : i_dig;
endmodule

// File: rtl/adc_bcd_converter.sv
// Converts each rising-edge-qualified ADC sample to 4 BCD digits, one bit per clock; done DATA_W+1 cycles after capture.
// No backpressure: start edges while busy are dropped. ADC_BCD_AVG_EN converts the mean of every 4 accepted samples.
module adc_bcd_converter
    import adc_bcd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_valid,
    output logic [3:0]        o_ones,
    output logic [3:0]        o_tens,
    output logic [3:0]        o_hundreds,
    output logic [3:0]        o_thousands,
    output logic              o_busy,
    output logic              o_done
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int BW = 4 * DIGITS;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [BW-1:0]     scr_q, scr_d;
    logic [BW-1:0]     out_q, out_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              vld_prev_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [BW-1:0]     scr_adj;
    logic [BW-1:0]     shift_bcd;
    logic [DATA_W-1:0] shift_sr;
    logic              start;
    logic              load;
    logic [DATA_W-1:0] load_dat;

    assign start = i_data_valid & ~vld_prev_q & (state_q == IDLE);

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_dig (scr_q[4*g +: 4]),
            .o_dig (scr_adj[4*g +: 4])
        );
    end

    assign shift_bcd = {scr_adj[BW-2:0], sr_q[DATA_W-1]};
    assign shift_sr  = {sr_q[DATA_W-2:0], 1'b0};

`ifdef ADC_BCD_AVG_EN
    localparam int AW     = DATA_W + 2;
    localparam int AVG_SH = $clog2(AVG_DEPTH);

    logic [AW-1:0]     acc_q, acc_d, acc_sum;
    logic [AVG_SH-1:0] navg_q, navg_d;

    // Only edges that would start a conversion count toward the average.
    always_comb begin
        acc_sum  = acc_q + AW'(i_data);
        acc_d    = acc_q;
        navg_d   = navg_q;
        load     = 1'b0;
        load_dat = acc_sum[AVG_SH +: DATA_W];
        if (start) begin
            if (navg_q == AVG_SH'(AVG_DEPTH - 1)) begin
                acc_d  = '0;
                navg_d = '0;
                load   = 1'b1;
            end else begin
                acc_d  = acc_sum;
                navg_d = navg_q + AVG_SH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            navg_q <= '0;
        end else begin
            acc_q  <= acc_d;
            navg_q <= navg_d;
        end
    end
`else
    assign load     = start;
    assign load_dat = i_data;
`endif

    // The final shift result goes straight to the output register so the
    // digits and o_done appear together while the FSM sits in DONE.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    sr_d    = load_dat;
                    scr_d   = '0;
                    cnt_d   = CW'(DATA_W);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = shift_sr;
                scr_d = shift_bcd;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    out_d   = shift_bcd;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            scr_q      <= '0;
            out_q      <= '0;
            cnt_q      <= '0;
            vld_prev_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            scr_q      <= scr_d;
            out_q      <= out_d;
            cnt_q      <= cnt_d;
            vld_prev_q <= i_data_valid;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_ones      = out_q[3:0];
    assign o_tens      = out_q[7:4];
    assign o_hundreds  = out_q[11:8];
    assign o_thousands = out_q[15:12];
    assign o_busy      = busy_q;
    assign o_done      = done_q;
endmodule

// File: tb/tb_adc_bcd_converter.sv
// Bench for adc_bcd_converter: table of samples with expected BCD, scoreboard queue popped on o_done.
module tb_adc_bcd_converter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] i_data;
    logic        i_data_valid;
    logic [3:0]  o_ones, o_tens, o_hundreds, o_thousands;
    logic        o_busy, o_done;

    always #5 clk = ~clk;

    adc_bcd_converter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_ones       (o_ones),
        .o_tens       (o_tens),
        .o_hundreds   (o_hundreds),
        .o_thousands  (o_thousands),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    typedef struct {
        logic [11:0] din;
        logic [15:0] bcd;
    } vec_t;

    vec_t        vecs[14];
    logic [15:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          dones, busy_cyc, first_done, cyc;

    function automatic logic [15:0] digits();
        return {o_thousands, o_hundreds, o_tens, o_ones};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_stats();
        dones      = 0;
        busy_cyc   = 0;
        first_done = -1;
        cyc        = 0;
    endtask

    // One clock; sample on the falling edge and retire a scoreboard entry on o_done.
    task automatic step();
        logic [15:0] e;
        @(negedge clk);
        cyc++;
        if (o_busy) busy_cyc++;
        if (o_done) begin
            dones++;
            if (first_done < 0) first_done = cyc;
            if (exp_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("digits", int'(digits()), int'(e));
            end
        end
    endtask

    task automatic pulse(input logic [11:0] din);
        i_data       = din;
        i_data_valid = 1'b1;
        step();
        i_data_valid = 1'b0;
        repeat (19) step();
    endtask

    task automatic run_conv(input logic [11:0] din, input logic [15:0] bcd);
        clr_stats();
        exp_q.push_back(bcd);
        pulse(din);
        chk("latency", first_done, 13);
        chk("busy_cycles", busy_cyc, 13);
        chk("done_count", dones, 1);
    endtask

    initial begin
        vecs[0]  = '{12'd1234, 16'h1234};
        vecs[1]  = '{12'd4095, 16'h4095};
        vecs[2]  = '{12'd0,    16'h0000};
        vecs[3]  = '{12'd999,  16'h0999};
        vecs[4]  = '{12'd500,  16'h0500};
        vecs[5]  = '{12'd42,   16'h0042};
        vecs[6]  = '{12'd1,    16'h0001};
        vecs[7]  = '{12'd9,    16'h0009};
        vecs[8]  = '{12'd10,   16'h0010};
        vecs[9]  = '{12'd99,   16'h0099};
        vecs[10] = '{12'd100,  16'h0100};
        vecs[11] = '{12'd1000, 16'h1000};
        vecs[12] = '{12'd2048, 16'h2048};
        vecs[13] = '{12'd3999, 16'h3999};

        rst_n        = 1'b0;
        i_data       = 12'hFFF;
        i_data_valid = 1'b0;
        clr_stats();
        repeat (3) step();
        chk("rst_digits", int'(digits()), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        rst_n = 1'b1;
        clr_stats();
        repeat (5) step();
        chk("post_rst_done", dones, 0);
        chk("post_rst_digits", int'(digits()), 0);
        chk("post_rst_busy", busy_cyc, 0);

`ifdef ADC_BCD_AVG_EN
        // 1000..1003 sum to 4006 -> 1001; 4 x 4095 -> 4095; 0..3 sum 6 -> 1.
        clr_stats();
        exp_q.push_back(16'h1001);
        pulse(12'd1000); pulse(12'd1001); pulse(12'd1002); pulse(12'd1003);
        chk("avg1_done_count", dones, 1);
        chk("avg1_latency", first_done, 73);

        clr_stats();
        exp_q.push_back(16'h4095);
        repeat (4) pulse(12'd4095);
        chk("avg2_done_count", dones, 1);
        chk("avg2_latency", first_done, 73);

        clr_stats();
        exp_q.push_back(16'h0001);
        pulse(12'd0); pulse(12'd1); pulse(12'd2); pulse(12'd3);
        chk("avg3_done_count", dones, 1);
        chk("avg3_latency", first_done, 73);
`else
        for (int i = 0; i < 14; i++) run_conv(vecs[i].din, vecs[i].bcd);

        // Second edge five cycles in is dropped; data change mid-flight ignored.
        clr_stats();
        exp_q.push_back(16'h1234);
        i_data       = 12'd1234;
        i_data_valid = 1'b1;
        step();
        i_data_valid = 1'b0;
        repeat (4) step();
        i_data       = 12'd999;
        i_data_valid = 1'b1;
        step();
        i_data_valid = 1'b0;
        repeat (20) step();
        chk("drop_done_count", dones, 1);
        chk("drop_latency", first_done, 13);
        run_conv(12'd999, 16'h0999);

        // Level valid: one conversion for a long high level.
        clr_stats();
        exp_q.push_back(16'h0500);
        i_data       = 12'd500;
        i_data_valid = 1'b1;
        repeat (40) step();
        i_data_valid = 1'b0;
        repeat (5) step();
        chk("level_done_count", dones, 1);

        // Mid-conversion reset aborts with no done.
        clr_stats();
        i_data       = 12'd1234;
        i_data_valid = 1'b1;
        step();
        i_data_valid = 1'b0;
        repeat (5) step();
        chk("mid_busy_before", int'(o_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_digits", int'(digits()), 0);
        chk("mid_rst_busy", int'(o_busy), 0);
        chk("mid_rst_done", int'(o_done), 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (20) step();
        chk("mid_rst_no_done", dones, 0);
        run_conv(12'd42, 16'h0042);

        // Valid already high when reset releases starts exactly one conversion.
        rst_n        = 1'b0;
        i_data       = 12'd500;
        i_data_valid = 1'b1;
        repeat (3) step();
        clr_stats();
        exp_q.push_back(16'h0500);
        rst_n = 1'b1;
        repeat (30) step();
        i_data_valid = 1'b0;
        repeat (5) step();
        chk("rel_done_count", dones, 1);
        chk("rel_latency", first_done, 13);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
